// File: rtl/sys_cmd_ctrl_pkg.sv
// Shared opcodes, operand addresses and FSM state encoding
// for the UART command-frame controller.
package sys_cmd_ctrl_pkg;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    OP_A,
    OP_B,
    ALU_FUN_S,
    ALU_WAIT,
    TX_LO,
    TX_HI
  } state_t;

endpackage

// File: rtl/sys_cmd_ctrl_tx_sender.sv
// Response byte sequencer: shifts out one or two bytes, LSB first,
// holding off while the TX FIFO reports full.
module sys_cmd_tx_sender #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    two,
  input  logic [2*DATA_WIDTH-1:0] word,
  input  logic                    full,
  output logic [DATA_WIDTH-1:0]   data,
  output logic                    vld,
  output logic                    last
);

  logic [2*DATA_WIDTH-1:0] shreg;
  logic [1:0]              left;

  // Write is gated by the live full flag so no byte is lost.
  assign vld  = (left != 2'd0) && !full;
  assign data = shreg[DATA_WIDTH-1:0];
  assign last = (left == 2'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      left  <= 2'd0;
    end else if (load) begin
      shreg <= word;
      left  <= two ? 2'd2 : 2'd1;
    end else if (vld) begin
      shreg <= shreg >> DATA_WIDTH;
      left  <= left - 2'd1;
    end
  end

endmodule

// File: rtl/sys_cmd_ctrl.sv
// Command-frame controller: RF write/read and ALU frames.
// ALU frames (0xCC/0xDD) exist only with SYS_CMD_CTRL_ALU_EN.
module sys_cmd_ctrl
  import sys_cmd_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_Data,
  input  logic                    RX_D_VLD,
  output logic [DATA_WIDTH-1:0]   TX_P_Data,
  output logic                    TX_D_VLD,
  input  logic                    TX_FULL,
  output logic [ADDR_WIDTH-1:0]   RF_Addr,
  output logic [DATA_WIDTH-1:0]   RF_WrData,
  output logic                    RF_WrEn,
  output logic                    RF_RdEn,
  input  logic [DATA_WIDTH-1:0]   RF_RdData,
  input  logic                    RF_RdData_VLD,
  output logic [3:0]              ALU_FUN,
  output logic                    ALU_EN,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  output logic                    CLK_GATE_EN
);

  state_t                  state;
  logic                    tx_load;
  logic                    tx_two;
  logic                    tx_last;
  logic [2*DATA_WIDTH-1:0] tx_word;

  wire rd_done = (state == RD_WAIT) && RF_RdData_VLD;

`ifdef SYS_CMD_CTRL_ALU_EN
  wire alu_done = (state == ALU_WAIT) && ALU_OUT_VLD;
`else
  wire alu_done = 1'b0;
  wire unused_alu = ^{ALU_OUT, ALU_OUT_VLD};
`endif

  assign tx_load = rd_done || alu_done;
  assign tx_two  = alu_done;
  assign tx_word = alu_done
    ? ALU_OUT
    : {{DATA_WIDTH{1'b0}}, RF_RdData};

  sys_cmd_tx_sender #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_tx (
    .clk  (CLK),
    .rst  (RST),
    .load (tx_load),
    .two  (tx_two),
    .word (tx_word),
    .full (TX_FULL),
    .data (TX_P_Data),
    .vld  (TX_D_VLD),
    .last (tx_last)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      RF_Addr   <= '0;
      RF_WrData <= '0;
      RF_WrEn   <= 1'b0;
      RF_RdEn   <= 1'b0;
`ifdef SYS_CMD_CTRL_ALU_EN
      ALU_FUN     <= '0;
      ALU_EN      <= 1'b0;
      CLK_GATE_EN <= 1'b0;
`endif
    end else begin
      RF_WrEn <= 1'b0;
      RF_RdEn <= 1'b0;
`ifdef SYS_CMD_CTRL_ALU_EN
      ALU_EN  <= 1'b0;
`endif
      case (state)
        IDLE: if (RX_D_VLD) begin
          case (RX_P_Data)
            CMD_RF_WR: state <= WR_ADDR;
            CMD_RF_RD: state <= RD_ADDR;
`ifdef SYS_CMD_CTRL_ALU_EN
            CMD_ALU_OP: begin
              state       <= OP_A;
              CLK_GATE_EN <= 1'b1;
            end
            CMD_ALU_NOP: begin
              state       <= ALU_FUN_S;
              CLK_GATE_EN <= 1'b1;
            end
`endif
            default: state <= IDLE;
          endcase
        end
        WR_ADDR: if (RX_D_VLD) begin
          RF_Addr <= RX_P_Data[ADDR_WIDTH-1:0];
          state   <= WR_DATA;
        end
        WR_DATA: if (RX_D_VLD) begin
          RF_WrData <= RX_P_Data;
          RF_WrEn   <= 1'b1;
          state     <= IDLE;
        end
        RD_ADDR: if (RX_D_VLD) begin
          RF_Addr <= RX_P_Data[ADDR_WIDTH-1:0];
          RF_RdEn <= 1'b1;
          state   <= RD_WAIT;
        end
        RD_WAIT: if (RF_RdData_VLD) begin
          state <= TX_LO;
        end
`ifdef SYS_CMD_CTRL_ALU_EN
        OP_A: if (RX_D_VLD) begin
          RF_Addr   <= ADDR_WIDTH'(OPA_ADDR);
          RF_WrData <= RX_P_Data;
          RF_WrEn   <= 1'b1;
          state     <= OP_B;
        end
        OP_B: if (RX_D_VLD) begin
          RF_Addr   <= ADDR_WIDTH'(OPB_ADDR);
          RF_WrData <= RX_P_Data;
          RF_WrEn   <= 1'b1;
          state     <= ALU_FUN_S;
        end
        ALU_FUN_S: if (RX_D_VLD) begin
          ALU_FUN <= RX_P_Data[3:0];
          ALU_EN  <= 1'b1;
          state   <= ALU_WAIT;
        end
        // Gate stays open through the result-valid cycle.
        ALU_WAIT: if (ALU_OUT_VLD) begin
          CLK_GATE_EN <= 1'b0;
          state       <= TX_LO;
        end
`endif
        TX_LO: if (TX_D_VLD) begin
          state <= tx_last ? IDLE : TX_HI;
        end
        TX_HI: if (TX_D_VLD) begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SYS_CMD_CTRL_ALU_EN
  assign ALU_FUN     = 4'd0;
  assign ALU_EN      = 1'b0;
  assign CLK_GATE_EN = 1'b0;
`endif

endmodule
